// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared defaults and FSM state type for the instruction-memory loader
package imem_loader_pkg;
   localparam int DEPTH_WORDS_DEF = 64;
   localparam int ADDR_W_DEF = 6;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int BYTES_PER_WORD = 4;
   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
endpackage

// File: rtl/imem_loader_pin_sync.sv
// pin_sync: multi-flop synchronizer for an asynchronous pin with rise/fall detect
module pin_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic lvl,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sync;
   logic prev;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[STAGES-2:0], pin};
         prev <= sync[STAGES-1];
      end
   assign lvl = sync[STAGES-1];
   assign rise = lvl & ~prev;
   assign fall = ~lvl & prev;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: assembles strobed bytes into 32-bit words and writes them into instruction memory
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic              byte_stb,
   input  logic [7:0]        byte_in,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   input  logic              imem_ready,
   output logic              cpu_hold,
   output logic              ack,
   output logic [ADDR_W:0]   word_count,
   output logic              full,
   output logic              err,
   output logic              done
);
   localparam int CW = $clog2(SYNC_STAGES + 1);
   localparam int BW = $clog2(BYTES_PER_WORD);
   state_t state, state_nxt;
   logic load_lvl, load_rise, load_fall, stb_rise, unused_stb_lvl, unused_stb_fall;
   logic [BW-1:0] byte_cnt;
   logic [CW-1:0] settle;
   logic armed, settled, start, accept, wr_ok, last_word, drop;
   pin_sync #(.STAGES(SYNC_STAGES)) u_load (.clk(clk), .rst(rst), .pin(load_en),
      .lvl(load_lvl), .rise(load_rise), .fall(load_fall));
   pin_sync #(.STAGES(SYNC_STAGES)) u_stb (.clk(clk), .rst(rst), .pin(byte_stb),
      .lvl(unused_stb_lvl), .rise(stb_rise), .fall(unused_stb_fall));
   assign settled = settle == CW'(SYNC_STAGES);
   assign start = state == IDLE && load_rise && armed;
   assign accept = state == COLLECT && stb_rise && load_lvl && !full;
   assign wr_ok = state == WRITE && imem_ready;
   assign last_word = imem_addr == ADDR_W'(DEPTH_WORDS - 1);
   // a strobe counts as dropped anywhere in a session, including IDLE while load_en stays high
   assign drop = stb_rise && !accept && (state != IDLE || load_lvl);
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? COLLECT : IDLE;
         COLLECT: state_nxt = !load_lvl ? DONE :
                              (accept && byte_cnt == BW'(BYTES_PER_WORD - 1)) ? WRITE : COLLECT;
         WRITE:   state_nxt = !imem_ready ? WRITE : (last_word || !load_lvl) ? DONE : COLLECT;
         default: state_nxt = IDLE;
      endcase
   end
   always_comb begin
      imem_we = state == WRITE;
      cpu_hold = state != IDLE;
      done = state == DONE;
   end
   // a load_en already high when reset releases must fall before it can start a session
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         settle <= '0;
         armed <= 1'b0;
      end else begin
         settle <= settled ? settle : settle + 1'b1;
         armed <= armed | load_fall | (settled & ~load_lvl);
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         byte_cnt <= '0;
         imem_addr <= '0;
         imem_wdata <= '0;
         word_count <= '0;
         full <= 1'b0;
         err <= 1'b0;
         ack <= 1'b0;
      end else begin
         if (start) begin
            imem_addr <= '0;
            byte_cnt <= '0;
            word_count <= '0;
            full <= 1'b0;
            err <= 1'b0;
         end else err <= err | drop;
         if (accept) begin
            imem_wdata[{byte_cnt, 3'b000} +: 8] <= byte_in;
            byte_cnt <= byte_cnt + 1'b1;
            ack <= ~ack;
         end
         if (wr_ok) begin
            word_count <= word_count + 1'b1;
            imem_addr <= imem_addr + 1'b1;
            byte_cnt <= '0;
            full <= full | last_word;
         end
      end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scenarios for the byte-to-word instruction memory loader
module tb_imem_loader;
   logic clk = 1'b0, rst = 1'b0, load_en = 1'b0, byte_stb = 1'b0, imem_ready = 1'b0;
   logic [7:0] byte_in = 8'h00;
   logic imem_we, cpu_hold, ack, full, err, done;
   logic [5:0] imem_addr;
   logic [31:0] imem_wdata;
   logic [6:0] word_count;
   logic [31:0] wd [0:127];
   logic [5:0] wa [0:127];
   int wr_cnt = 0, done_cnt = 0, total = 0, passed = 0;

   imem_loader dut (.clk(clk), .rst(rst), .load_en(load_en), .byte_stb(byte_stb), .byte_in(byte_in),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ready(imem_ready),
      .cpu_hold(cpu_hold), .ack(ack), .word_count(word_count), .full(full), .err(err), .done(done));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      #1;
      if (!rst && imem_we && imem_ready && wr_cnt < 128) begin
         wd[wr_cnt] = imem_wdata;
         wa[wr_cnt] = imem_addr;
         wr_cnt++;
      end
      if (done) done_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      byte_in = b;
      byte_stb = 1'b1;
      tick(4);
      byte_stb = 1'b0;
      tick(3);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(3);
      total++; if (imem_we !== 1'b0) $display("FAIL rst_we got %b exp 0", imem_we); else passed++;
      total++; if (imem_addr !== 6'd0) $display("FAIL rst_addr got %0d exp 0", imem_addr); else passed++;
      total++; if (imem_wdata !== 32'd0) $display("FAIL rst_wdata got %h exp 0", imem_wdata); else passed++;
      total++; if (cpu_hold !== 1'b0) $display("FAIL rst_hold got %b exp 0", cpu_hold); else passed++;
      total++; if (ack !== 1'b0) $display("FAIL rst_ack got %b exp 0", ack); else passed++;
      total++; if (word_count !== 7'd0) $display("FAIL rst_wc got %0d exp 0", word_count); else passed++;
      total++; if ({full, err, done} !== 3'b000) $display("FAIL rst_flags got %b exp 000", {full, err, done}); else passed++;
      rst = 1'b0;
      tick(6);
   endtask

   task automatic test_basic;
      logic a0;
      imem_ready = 1'b1;
      load_en = 1'b1;
      tick(5);
      total++; if (cpu_hold !== 1'b1) $display("FAIL basic_hold_on got %b exp 1", cpu_hold); else passed++;
      a0 = ack;
      send(8'h13);
      total++; if (ack !== ~a0) $display("FAIL basic_ack got %b exp %b", ack, ~a0); else passed++;
      send(8'h00); send(8'h00); send(8'h00);
      send(8'h93); send(8'h00); send(8'h10); send(8'h00);
      load_en = 1'b0;
      tick(8);
      total++; if (wr_cnt !== 2) $display("FAIL basic_writes got %0d exp 2", wr_cnt); else passed++;
      total++; if (wd[0] !== 32'h00000013) $display("FAIL basic_w0 got %h exp 00000013", wd[0]); else passed++;
      total++; if (wa[0] !== 6'd0) $display("FAIL basic_a0 got %0d exp 0", wa[0]); else passed++;
      total++; if (wd[1] !== 32'h00100093) $display("FAIL basic_w1 got %h exp 00100093", wd[1]); else passed++;
      total++; if (wa[1] !== 6'd1) $display("FAIL basic_a1 got %0d exp 1", wa[1]); else passed++;
      total++; if (word_count !== 7'd2) $display("FAIL basic_wc got %0d exp 2", word_count); else passed++;
      total++; if (done_cnt !== 1) $display("FAIL basic_done got %0d exp 1", done_cnt); else passed++;
      total++; if (cpu_hold !== 1'b0) $display("FAIL basic_hold_off got %b exp 0", cpu_hold); else passed++;
   endtask

   task automatic test_stall_err;
      logic a0;
      load_en = 1'b1;
      imem_ready = 1'b0;
      tick(5);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      for (int i = 0; i < 5; i++) begin
         total++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 6'd0, 32'h44332211})
            $display("FAIL stall_hold%0d got %b/%0d/%h exp 1/0/44332211", i, imem_we, imem_addr, imem_wdata); else passed++;
         tick(1);
      end
      total++; if (wr_cnt !== 2) $display("FAIL stall_nowrite got %0d exp 2", wr_cnt); else passed++;
      a0 = ack;
      send(8'hEE);
      total++; if (err !== 1'b1) $display("FAIL stall_err got %b exp 1", err); else passed++;
      total++; if (ack !== a0) $display("FAIL stall_ack got %b exp %b", ack, a0); else passed++;
      total++; if (imem_wdata !== 32'h44332211) $display("FAIL stall_data got %h exp 44332211", imem_wdata); else passed++;
      imem_ready = 1'b1;
      tick(2);
      total++; if (wr_cnt !== 3) $display("FAIL stall_release got %0d exp 3", wr_cnt); else passed++;
      total++; if (wd[2] !== 32'h44332211) $display("FAIL stall_w0 got %h exp 44332211", wd[2]); else passed++;
      send(8'h55); send(8'h66); send(8'h77); send(8'h88);
      tick(2);
      total++; if (wd[3] !== 32'h88776655 || wa[3] !== 6'd1)
         $display("FAIL stall_w1 got %h@%0d exp 88776655@1", wd[3], wa[3]); else passed++;
      load_en = 1'b0;
      tick(8);
      total++; if (word_count !== 7'd2 || done_cnt !== 2)
         $display("FAIL stall_end got wc=%0d done=%0d exp wc=2 done=2", word_count, done_cnt); else passed++;
   endtask

   task automatic test_partial;
      load_en = 1'b1;
      tick(5);
      total++; if (err !== 1'b0) $display("FAIL part_errclr got %b exp 0", err); else passed++;
      send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
      send(8'h01); send(8'h02);
      load_en = 1'b0;
      tick(8);
      total++; if (wr_cnt !== 5) $display("FAIL part_writes got %0d exp 5", wr_cnt); else passed++;
      total++; if (wd[4] !== 32'hD4C3B2A1 || wa[4] !== 6'd0)
         $display("FAIL part_w0 got %h@%0d exp D4C3B2A1@0", wd[4], wa[4]); else passed++;
      total++; if (word_count !== 7'd1) $display("FAIL part_wc got %0d exp 1", word_count); else passed++;
      total++; if (done_cnt !== 3) $display("FAIL part_done got %0d exp 3", done_cnt); else passed++;
   endtask

   task automatic test_full;
      logic a0;
      load_en = 1'b1;
      tick(5);
      for (int w = 0; w < 64; w++)
         for (int k = 0; k < 4; k++) send(8'(4 * w + k));
      total++; if (wr_cnt !== 69) $display("FAIL full_writes got %0d exp 69", wr_cnt); else passed++;
      total++; if (wd[5] !== 32'h03020100 || wa[5] !== 6'd0)
         $display("FAIL full_first got %h@%0d exp 03020100@0", wd[5], wa[5]); else passed++;
      total++; if (wd[68] !== 32'hFFFEFDFC || wa[68] !== 6'd63)
         $display("FAIL full_last got %h@%0d exp FFFEFDFC@63", wd[68], wa[68]); else passed++;
      total++; if (full !== 1'b1) $display("FAIL full_flag got %b exp 1", full); else passed++;
      total++; if (imem_addr !== 6'd0) $display("FAIL full_wrap got %0d exp 0", imem_addr); else passed++;
      total++; if (word_count !== 7'd64) $display("FAIL full_wc got %0d exp 64", word_count); else passed++;
      total++; if (err !== 1'b0) $display("FAIL full_noerr got %b exp 0", err); else passed++;
      a0 = ack;
      for (int k = 0; k < 4; k++) send(8'hC0 + 8'(k));
      total++; if (err !== 1'b1) $display("FAIL full_err got %b exp 1", err); else passed++;
      total++; if (ack !== a0) $display("FAIL full_ack got %b exp %b", ack, a0); else passed++;
      total++; if (wr_cnt !== 69 || word_count !== 7'd64)
         $display("FAIL full_extra got wr=%0d wc=%0d exp wr=69 wc=64", wr_cnt, word_count); else passed++;
      load_en = 1'b0;
      tick(6);
      total++; if (done_cnt !== 4) $display("FAIL full_done got %0d exp 4", done_cnt); else passed++;
   endtask

   task automatic test_reset_write;
      load_en = 1'b1;
      imem_ready = 1'b0;
      tick(5);
      total++; if (full !== 1'b0) $display("FAIL rw_fullclr got %b exp 0", full); else passed++;
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      total++; if (imem_we !== 1'b1) $display("FAIL rw_inwrite got %b exp 1", imem_we); else passed++;
      rst = 1'b1;
      #1;
      total++; if ({imem_we, cpu_hold} !== 2'b00) $display("FAIL rw_async got %b exp 00", {imem_we, cpu_hold}); else passed++;
      total++; if (imem_wdata !== 32'd0) $display("FAIL rw_wdata got %h exp 0", imem_wdata); else passed++;
      tick(2);
      rst = 1'b0;
      imem_ready = 1'b1;
      tick(10);
      total++; if (cpu_hold !== 1'b0) $display("FAIL rw_nostart got %b exp 0", cpu_hold); else passed++;
      total++; if (wr_cnt !== 69) $display("FAIL rw_nowrite got %0d exp 69", wr_cnt); else passed++;
      load_en = 1'b0;
      tick(5);
      load_en = 1'b1;
      tick(5);
      total++; if (cpu_hold !== 1'b1) $display("FAIL rw_restart got %b exp 1", cpu_hold); else passed++;
      load_en = 1'b0;
      tick(8);
      total++; if (cpu_hold !== 1'b0 || done_cnt !== 5)
         $display("FAIL rw_end got hold=%b done=%0d exp hold=0 done=5", cpu_hold, done_cnt); else passed++;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_stall_err;
      test_partial;
      test_full;
      test_reset_write;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, instruction-memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter ADDR_W, default 6, equal to log2(DEPTH_WORDS).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, flops in each pin synchronizer (minimum 2).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 load_en  in  1  raw pin, asynchronous; high = load session requested.
REQ-007 byte_stb  in  1  raw pin, asynchronous; rising edge = byte_in valid.
REQ-008 byte_in  in  8  program byte; external driver holds it stable from strobe rise until ack toggles.
REQ-009 imem_we  out  1  instruction-memory write request.
REQ-010 imem_addr  out  ADDR_W  word address of current write.
REQ-011 imem_wdata  out  32  assembled instruction word.
REQ-012 imem_ready  in  1  memory accepts write on a cycle with imem_we=1 and imem_ready=1.
REQ-013 cpu_hold  out  1  holds CPU pipeline in reset while loading.
REQ-014 ack  out  1  toggles once per accepted byte.
REQ-015 word_count  out  ADDR_W+1  words written in current/last session.
REQ-016 full  out  1  sticky: all DEPTH_WORDS words written.
REQ-017 err  out  1  sticky: strobe edge dropped (arrived outside COLLECT during session).
REQ-018 done  out  1  one-cycle pulse at session end.

Function
REQ-019 load_en and byte_stb SHALL each pass a SYNC_STAGES synchronizer plus rising/falling edge detect; byte_in SHALL be sampled on the cycle the synchronized strobe rise is detected (SYNC_STAGES+1 cycles after pin rise).
REQ-020 FSM states: IDLE, COLLECT, WRITE, DONE.
REQ-021 IDLE -> COLLECT on synchronized load_en rise; same edge clears imem_addr, byte counter, word_count, full, err.
REQ-022 COLLECT: each strobe rise stores byte_in at lane byte_cnt (little-endian, byte 0 -> bits 7:0), increments byte_cnt, toggles ack next cycle; 4th byte -> WRITE.
REQ-023 COLLECT with load_en low (falling edge or level) -> DONE; partial word discarded, never written.
REQ-024 WRITE: imem_we=1, imem_wdata/imem_addr stable until imem_ready=1; on accept cycle word_count+1, imem_addr+1, byte_cnt=0.
REQ-025 After accept: if word written was at DEPTH_WORDS-1, set full and -> DONE (imem_addr wraps to 0); else if load_en low -> DONE; else -> COLLECT.
REQ-026 Load_en fall during WRITE SHALL NOT abort the pending write; it completes first.
REQ-027 Strobe rise in WRITE or DONE, or in COLLECT after full, SHALL be dropped, set err, not toggle ack.
REQ-028 DONE: done=1 for exactly one cycle, then -> IDLE; new session requires a fresh load_en rise.
REQ-029 cpu_hold = 1 in COLLECT, WRITE, DONE; 0 in IDLE (combinational from state register, glitch-free decode).
REQ-030 imem_we SHALL be 1 only in WRITE.

Reset
REQ-031 rst SHALL asynchronously force: state IDLE, imem_we 0, imem_addr 0, imem_wdata 0, cpu_hold 0, ack 0, word_count 0, full 0, err 0, done 0, synchronizer flops 0.
REQ-032 rst mid-session SHALL abandon any pending write without further imem_we; a load_en already high at release SHALL NOT start a session until it falls and rises again.

Structure
REQ-033 Package imem_loader_pkg SHALL hold the state enum, default DEPTH_WORDS/ADDR_W/SYNC_STAGES, BYTES_PER_WORD=4.
REQ-034 Sub-module pin_sync (SYNC_STAGES synchronizer + rise/fall detect) SHALL be instantiated twice (load_en, byte_stb).

Verification
REQ-035 Load bytes 13,00,00,00 / 93,00,10,00 with imem_ready=1 then drop load_en -> writes 0x00000013@0, 0x00100093@1; word_count=2; done pulse; cpu_hold 1->0.
REQ-036 imem_ready held 0 for 5 cycles in WRITE -> imem_we, addr, wdata constant 5 cycles; single write on 6th.
REQ-037 Drop load_en after 2 bytes of word 1 -> no write for partial word; word_count=1; done pulse.
REQ-038 Stream 65 words (260 bytes) with DEPTH_WORDS=64 -> 64 writes, full=1, imem_addr=0, extra 4 strobes set err, ack unchanged.
REQ-039 Strobe edge during stalled WRITE -> err=1, byte not stored, next word assembles correctly.
REQ-040 rst asserted in WRITE with load_en held high -> imem_we 0 same cycle; no session after release until load_en toggles.
